// File: rtl/rs_alu_if.sv
// rs_alu_if: issue, CDB snoop and FU dispatch bundle of the ALU reservation station.
//   master : upstream side (drives flush, issue request, CDB broadcasts, fu_ready)
//   slave  : reservation station (drives issue_ready, fu_* dispatch outputs, count)
//   Issue  : issue_valid/issue_ready, op_in, vj_in, vk_in, qj_in, qk_in, dest_in
//   CDB    : cdb_valid, cdb_rob_idx, cdb_data (channel 0 in the LSBs)
//   FU     : fu_valid/fu_ready, fu_op, fu_vj, fu_vk, fu_dest
//   Status : flush (sync squash), count (busy entries)
interface rs_alu_if #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 4,
    parameter int NUM_CDB = 2
);
    logic                         flush;
    logic                         issue_valid;
    logic                         issue_ready;
    logic [OP_W-1:0]              op_in;
    logic [XLEN-1:0]              vj_in;
    logic [XLEN-1:0]              vk_in;
    logic [ROB_W-1:0]             qj_in;
    logic [ROB_W-1:0]             qk_in;
    logic [ROB_W-1:0]             dest_in;
    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*ROB_W-1:0]     cdb_rob_idx;
    logic [NUM_CDB*XLEN-1:0]      cdb_data;
    logic                         fu_valid;
    logic                         fu_ready;
    logic [OP_W-1:0]              fu_op;
    logic [XLEN-1:0]              fu_vj;
    logic [XLEN-1:0]              fu_vk;
    logic [ROB_W-1:0]             fu_dest;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, issue_valid, op_in, vj_in, vk_in, qj_in, qk_in, dest_in,
               cdb_valid, cdb_rob_idx, cdb_data, fu_ready,
        input  issue_ready, fu_valid, fu_op, fu_vj, fu_vk, fu_dest, count
    );

    modport slave (
        input  flush, issue_valid, op_in, vj_in, vk_in, qj_in, qk_in, dest_in,
               cdb_valid, cdb_rob_idx, cdb_data, fu_ready,
        output issue_ready, fu_valid, fu_op, fu_vj, fu_vk, fu_dest, count
    );
endinterface

// File: rtl/rs_alu_param.sv
// rs_alu_param: parametrised ALU reservation station with oldest-first dispatch.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rs_alu_if.slave -- issue port, CDB snoop, FU dispatch register, flush, count
// Optional: define RS_WAKEUP_BYPASS_EN to let an entry whose last pending tag is on
// the CDB this cycle dispatch immediately, with the broadcast data forwarded to fu_vj/fu_vk.
module rs_alu_param #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 4,
    parameter int NUM_CDB = 2
) (
    input  logic     clk,
    input  logic     rst,
    rs_alu_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]  busy;
    logic [OP_W-1:0]   op_r   [DEPTH];
    logic [XLEN-1:0]   vj_r   [DEPTH];
    logic [XLEN-1:0]   vk_r   [DEPTH];
    logic [ROB_W-1:0]  qj_r   [DEPTH];
    logic [ROB_W-1:0]  qk_r   [DEPTH];
    logic [ROB_W-1:0]  dest_r [DEPTH];
    // older_than[i][j] set means entry j was allocated before entry i
    logic [DEPTH-1:0]  older_than [DEPTH];
    logic [CW-1:0]     cnt;

    logic [DEPTH-1:0]  j_hit;
    logic [DEPTH-1:0]  k_hit;
    logic [DEPTH-1:0]  rdy;
    logic [XLEN-1:0]   j_data [DEPTH];
    logic [XLEN-1:0]   k_data [DEPTH];
    logic              in_j_hit;
    logic              in_k_hit;
    logic [XLEN-1:0]   in_j_data;
    logic [XLEN-1:0]   in_k_data;
    logic [IW-1:0]     free_idx;
    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic [XLEN-1:0]   sel_vj;
    logic [XLEN-1:0]   sel_vk;
    logic              alloc;
    logic              load;
    logic              rel;

    // Returns {hit, data}; channels scanned high to low so the lowest matching channel wins.
    function automatic logic [XLEN:0] snoop(
        input logic [ROB_W-1:0]         q,
        input logic [NUM_CDB-1:0]       v,
        input logic [NUM_CDB*ROB_W-1:0] t,
        input logic [NUM_CDB*XLEN-1:0]  d
    );
        logic [XLEN:0] r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--)
            if (v[c] && q != '0 && t[c*ROB_W +: ROB_W] == q)
                r = {1'b1, d[c*XLEN +: XLEN]};
        return r;
    endfunction

    always_comb begin
        {in_j_hit, in_j_data} = snoop(bus.qj_in, bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_data);
        {in_k_hit, in_k_data} = snoop(bus.qk_in, bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_data);
        for (int i = 0; i < DEPTH; i++) begin
            {j_hit[i], j_data[i]} = snoop(qj_r[i], bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_data);
            {k_hit[i], k_data[i]} = snoop(qk_r[i], bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_data);
`ifdef RS_WAKEUP_BYPASS_EN
            rdy[i] = busy[i] && (qj_r[i] == '0 || j_hit[i]) && (qk_r[i] == '0 || k_hit[i]);
`else
            rdy[i] = busy[i] && qj_r[i] == '0 && qk_r[i] == '0;
`endif
        end
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!busy[i])
                free_idx = IW'(i);
        // Ready entry with no older ready entry; allocation order is total, so it is unique.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++)
            if (rdy[i] && (older_than[i] & rdy) == '0) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
`ifdef RS_WAKEUP_BYPASS_EN
        sel_vj = j_hit[sel_idx] ? j_data[sel_idx] : vj_r[sel_idx];
        sel_vk = k_hit[sel_idx] ? k_data[sel_idx] : vk_r[sel_idx];
`else
        sel_vj = vj_r[sel_idx];
        sel_vk = vk_r[sel_idx];
`endif
    end

    // issue_ready comes from the pre-edge busy state, so a slot being dispatched this
    // cycle only becomes reusable next cycle.
    assign bus.issue_ready = ~&busy;
    assign bus.count       = cnt;
    assign alloc           = bus.issue_valid && bus.issue_ready;
    assign load            = !bus.fu_valid || bus.fu_ready;
    assign rel             = load && sel_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            cnt          <= '0;
            bus.fu_valid <= 1'b0;
            bus.fu_op    <= '0;
            bus.fu_vj    <= '0;
            bus.fu_vk    <= '0;
            bus.fu_dest  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]       <= '0;
                vj_r[i]       <= '0;
                vk_r[i]       <= '0;
                qj_r[i]       <= '0;
                qk_r[i]       <= '0;
                dest_r[i]     <= '0;
                older_than[i] <= '0;
            end
        end else if (bus.flush) begin
            busy         <= '0;
            cnt          <= '0;
            bus.fu_valid <= 1'b0;
            bus.fu_op    <= '0;
            bus.fu_vj    <= '0;
            bus.fu_vk    <= '0;
            bus.fu_dest  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]       <= '0;
                vj_r[i]       <= '0;
                vk_r[i]       <= '0;
                qj_r[i]       <= '0;
                qk_r[i]       <= '0;
                dest_r[i]     <= '0;
                older_than[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && j_hit[i]) begin
                    vj_r[i] <= j_data[i];
                    qj_r[i] <= '0;
                end
                if (busy[i] && k_hit[i]) begin
                    vk_r[i] <= k_data[i];
                    qk_r[i] <= '0;
                end
            end
            if (rel)
                busy[sel_idx] <= 1'b0;
            if (alloc) begin
                busy[free_idx]       <= 1'b1;
                op_r[free_idx]       <= bus.op_in;
                dest_r[free_idx]     <= bus.dest_in;
                vj_r[free_idx]       <= in_j_hit ? in_j_data : bus.vj_in;
                vk_r[free_idx]       <= in_k_hit ? in_k_data : bus.vk_in;
                qj_r[free_idx]       <= in_j_hit ? '0 : bus.qj_in;
                qk_r[free_idx]       <= in_k_hit ? '0 : bus.qk_in;
                // Everything already resident is older than the newcomer.
                older_than[free_idx] <= busy;
                for (int j = 0; j < DEPTH; j++)
                    older_than[j][free_idx] <= 1'b0;
            end
            if (load) begin
                bus.fu_valid <= sel_found;
                bus.fu_op    <= sel_found ? op_r[sel_idx] : '0;
                bus.fu_vj    <= sel_found ? sel_vj : '0;
                bus.fu_vk    <= sel_found ? sel_vk : '0;
                bus.fu_dest  <= sel_found ? dest_r[sel_idx] : '0;
            end
            cnt <= cnt + CW'(alloc) - CW'(rel);
        end
    end
endmodule

// File: tb/tb_rs_alu_param.sv
// tb_rs_alu_param: directed self-checking bench for rs_alu_param (DEPTH=4, 2 CDB channels).
module tb_rs_alu_param;
    localparam int DEPTH   = 4;
    localparam int XLEN    = 32;
    localparam int ROB_W   = 4;
    localparam int OP_W    = 4;
    localparam int NUM_CDB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [72:0] fu_o;
    logic [72:0] exp;

    always #5 clk = ~clk;

    rs_alu_if #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) bus ();

    rs_alu_param #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {fu_valid, fu_op, fu_dest, fu_vj, fu_vk}
    assign fu_o = {bus.fu_valid, bus.fu_op, bus.fu_dest, bus.fu_vj, bus.fu_vk};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        bus.op_in       = '0;
        bus.vj_in       = '0;
        bus.vk_in       = '0;
        bus.qj_in       = '0;
        bus.qk_in       = '0;
        bus.dest_in     = '0;
        bus.cdb_valid   = '0;
        bus.cdb_rob_idx = '0;
        bus.cdb_data    = '0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dest);
        bus.issue_valid = 1'b1;
        bus.op_in       = op;
        bus.vj_in       = vj;
        bus.vk_in       = vk;
        bus.qj_in       = qj;
        bus.qk_in       = qk;
        bus.dest_in     = dest;
    endtask

    task automatic cdb(input logic [1:0] v, input logic [3:0] t1, input logic [3:0] t0,
                       input logic [31:0] d1, input logic [31:0] d0);
        bus.cdb_valid   = v;
        bus.cdb_rob_idx = {t1, t0};
        bus.cdb_data    = {d1, d0};
    endtask

    task automatic test_reset();
        idle();
        bus.fu_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus.fu_valid, bus.count, bus.issue_ready} !== {1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_ctl got %b want %b", {bus.fu_valid, bus.count, bus.issue_ready}, 5'b00001);
        end
        checks++;
        if (fu_o !== '0) begin
            errors++;
            $display("FAIL reset_fu got %h want 0", fu_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        issue(3, 5, 7, 0, 0, 2);
        step();
        idle();
        checks++;
        if ({bus.fu_valid, bus.count} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL basic_alloc got %b want %b", {bus.fu_valid, bus.count}, 4'b0001);
        end
        step();
        exp = {1'b1, 4'd3, 4'd2, 32'd5, 32'd7};
        checks++;
        if (fu_o !== exp) begin
            errors++;
            $display("FAIL basic_out got %h want %h", fu_o, exp);
        end
        checks++;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL basic_count got %0d want 0", bus.count);
        end
        step();
        checks++;
        if (fu_o !== '0) begin
            errors++;
            $display("FAIL basic_drain got %h want 0", fu_o);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 32'(16 + i), 9, 0, 4'(i + 1));
            step();
        end
        checks++;
        if ({bus.count, bus.issue_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_state got %b want %b", {bus.count, bus.issue_ready}, 4'b1000);
        end
        issue(1, 0, 0, 9, 0, 15);
        step();
        idle();
        checks++;
        if (bus.count !== 3'd4) begin
            errors++;
            $display("FAIL full_ignore got %0d want 4", bus.count);
        end
        cdb(2'b10, 9, 0, 32'hAB, 0);
        step();
        idle();
`ifndef RS_WAKEUP_BYPASS_EN
        checks++;
        if (bus.fu_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_wake_early got %b want 0", bus.fu_valid);
        end
        step();
`endif
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 4'd1, 4'(i + 1), 32'hAB, 32'(16 + i)};
            checks++;
            if (fu_o !== exp) begin
                errors++;
                $display("FAIL full_order%0d got %h want %h", i, fu_o, exp);
            end
            checks++;
            if (bus.count !== 3'(3 - i)) begin
                errors++;
                $display("FAIL full_count%0d got %0d want %0d", i, bus.count, 3 - i);
            end
            if (i == 0) begin
                checks++;
                if (bus.issue_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_ready_rise got %b want 1", bus.issue_ready);
                end
            end
            step();
        end
        checks++;
        if (bus.fu_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got %b want 0", bus.fu_valid);
        end
    endtask

    task automatic test_stall();
        bus.fu_ready = 1'b0;
        issue(1, 1, 2, 0, 0, 5);
        step();
        issue(2, 3, 4, 0, 0, 6);
        step();
        issue(3, 5, 6, 0, 0, 7);
        step();
        idle();
        exp = {1'b1, 4'd1, 4'd5, 32'd1, 32'd2};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fu_o !== exp || bus.count !== 3'd2) begin
                errors++;
                $display("FAIL stall_hold%0d got %h/%0d want %h/2", k, fu_o, bus.count, exp);
            end
            if (k < 3)
                step();
        end
        bus.fu_ready = 1'b1;
        step();
        exp = {1'b1, 4'd2, 4'd6, 32'd3, 32'd4};
        checks++;
        if (fu_o !== exp || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL stall_first got %h/%0d want %h/1", fu_o, bus.count, exp);
        end
        step();
        exp = {1'b1, 4'd3, 4'd7, 32'd5, 32'd6};
        checks++;
        if (fu_o !== exp || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL stall_second got %h/%0d want %h/0", fu_o, bus.count, exp);
        end
        step();
    endtask

    // Older entry sits at a higher index than a younger one; age, not index, must win.
    task automatic test_age();
        issue(4, 32'h9, 0, 0, 0, 9);
        step();
        issue(5, 0, 32'h5, 7, 0, 8);
        step();
        bus.fu_ready = 1'b0;
        issue(6, 32'hC, 0, 0, 0, 10);
        cdb(2'b01, 0, 7, 0, 32'h77);
        step();
        idle();
        checks++;
        if ({bus.fu_valid, bus.fu_dest, bus.count} !== {1'b1, 4'd9, 3'd2}) begin
            errors++;
            $display("FAIL age_setup got %h want %h", {bus.fu_valid, bus.fu_dest, bus.count}, {1'b1, 4'd9, 3'd2});
        end
        bus.fu_ready = 1'b1;
        step();
        exp = {1'b1, 4'd5, 4'd8, 32'h77, 32'h5};
        checks++;
        if (fu_o !== exp) begin
            errors++;
            $display("FAIL age_oldest got %h want %h", fu_o, exp);
        end
        step();
        exp = {1'b1, 4'd6, 4'd10, 32'hC, 32'h0};
        checks++;
        if (fu_o !== exp) begin
            errors++;
            $display("FAIL age_younger got %h want %h", fu_o, exp);
        end
        step();
    endtask

    task automatic test_capture();
        issue(7, 0, 32'h22, 5, 0, 3);
        cdb(2'b01, 0, 5, 0, 32'h11);
        step();
        idle();
        step();
        exp = {1'b1, 4'd7, 4'd3, 32'h11, 32'h22};
        checks++;
        if (fu_o !== exp) begin
            errors++;
            $display("FAIL capture got %h want %h", fu_o, exp);
        end
        step();
        checks++;
        if ({bus.fu_valid, bus.count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL capture_drain got %b want 0000", {bus.fu_valid, bus.count});
        end
    endtask

    task automatic test_dual_wake();
        issue(8, 0, 0, 3, 4, 4);
        step();
        idle();
        cdb(2'b11, 4, 3, 32'h40, 32'h30);
        step();
        idle();
`ifndef RS_WAKEUP_BYPASS_EN
        checks++;
        if ({bus.fu_valid, bus.count} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL dual_early got %b want 0001", {bus.fu_valid, bus.count});
        end
        step();
`endif
        exp = {1'b1, 4'd8, 4'd4, 32'h30, 32'h40};
        checks++;
        if (fu_o !== exp) begin
            errors++;
            $display("FAIL dual_wake got %h want %h", fu_o, exp);
        end
        issue(9, 0, 32'h1, 6, 0, 5);
        step();
        idle();
        cdb(2'b11, 6, 6, 32'h61, 32'h60);
        step();
        idle();
`ifndef RS_WAKEUP_BYPASS_EN
        step();
`endif
        exp = {1'b1, 4'd9, 4'd5, 32'h60, 32'h1};
        checks++;
        if (fu_o !== exp) begin
            errors++;
            $display("FAIL cdb_priority got %h want %h", fu_o, exp);
        end
        step();
    endtask

    task automatic test_flush();
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1, 32'(i), 0, 0, 0, 4'(i + 1));
            step();
        end
        idle();
        checks++;
        if ({bus.fu_valid, bus.count} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL flush_setup got %b want 1011", {bus.fu_valid, bus.count});
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++;
        if ({bus.fu_valid, bus.count, bus.issue_ready} !== {1'b0, 3'd0, 1'b1} || fu_o !== '0) begin
            errors++;
            $display("FAIL flush_clear got %b/%h want 00001/0", {bus.fu_valid, bus.count, bus.issue_ready}, fu_o);
        end
        bus.fu_ready = 1'b1;
        step();
        checks++;
        if ({bus.fu_valid, bus.count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL flush_after got %b want 0000", {bus.fu_valid, bus.count});
        end
    endtask

    task automatic test_async_reset();
        bus.fu_ready = 1'b0;
        issue(2, 1, 1, 0, 0, 1);
        step();
        issue(2, 2, 2, 0, 0, 2);
        step();
        idle();
        checks++;
        if ({bus.fu_valid, bus.count} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL areset_setup got %b want 1001", {bus.fu_valid, bus.count});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.fu_valid, bus.count, bus.issue_ready} !== {1'b0, 3'd0, 1'b1} || fu_o !== '0) begin
            errors++;
            $display("FAIL areset_clear got %b/%h want 00001/0", {bus.fu_valid, bus.count, bus.issue_ready}, fu_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.fu_ready = 1'b1;
        step();
        checks++;
        if ({bus.fu_valid, bus.count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL areset_after got %b want 0000", {bus.fu_valid, bus.count});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_stall();
        test_age();
        test_capture();
        test_dual_wake();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
